stream_demux: RTL
=================

# stream_demux

Registered 1-to-2 stream demultiplexer: the routing counterpart to the team's `mux` block. It accepts a valid/ready stream of WIDTH-bit beats grouped into packets. It steers each whole packet to output 0 or output 1, based on `in_sel` sampled on the packet's first beat. Each output has a one-entry register, so the two destinations drain independently and there is no combinational path from input data to output data.

## Interface

- `WIDTH`, default 5, data width of every beat.

- `clk`  in  1  rising-edge clock for all state.
- `rst_n`  in  1  asynchronous active-low reset.
- `in_valid`  in  1  input beat present.
- `in_ready`  out  1  input beat accepted this cycle when high together with `in_valid`.
- `in_data`  in  WIDTH  input beat payload.
- `in_last`  in  1  marks the final beat of a packet.
- `in_sel`  in  1  destination of the packet (0 selects out0, 1 selects out1). Sampled only on a packet's first beat.
- `out0_valid` / `out1_valid`  out  1  output register holds a beat.
- `out0_ready` / `out1_ready`  in  1  downstream accepts the beat.
- `out0_data` / `out1_data`  out  WIDTH  buffered payload.
- `out0_last` / `out1_last`  out  1  buffered last flag.

## Operation

- Accept: a beat is accepted when `in_valid & in_ready` at a rising edge.
- FSM states are IDLE, LOCK0 and LOCK1.
  - IDLE: the destination is `in_sel`.
    - Accepted beat with `in_last=1`: stay in IDLE.
    - Accepted beat with `in_last=0`: go to LOCK`in_sel`.
  - LOCKn: the destination is n and `in_sel` is ignored.
    - Accepted beat with `in_last=1`: go to IDLE.
    - Otherwise stay in LOCKn.
- Output register n (valid, data, last):
  - Loads the accepted beat when the destination is n.
  - Clears valid on `outn_valid & outn_ready` if there is no simultaneous load.
  - Simultaneous drain and load: the register takes the new beat and valid stays 1.
- `in_ready` = (destination register empty) OR (`outn_ready` for that destination). It is combinational from `in_sel` in IDLE, from state, and from `outn_ready`. It never depends on `in_valid`.
- The non-destination output is untouched and may drain or stall freely.
- While `outn_valid=1` and `outn_ready=0`, `outn_data` and `outn_last` are held stable.
- Beats are delivered in acceptance order per output, with no loss and no duplication.
- Empty packets do not exist. A beat with `in_last=1` in IDLE is a complete one-beat packet.

## Timing

- Reset (asynchronous, `rst_n=0`):
  - state = IDLE.
  - `out0_valid` = `out1_valid` = 0, `outn_data` = 0, `outn_last` = 0.
  - `in_ready` = 1, because both registers are empty.
- Reset asserted mid-packet discards all buffered beats and packet state. The first accepted beat after release is treated as a packet start.
- Latency: a beat accepted at edge k appears on `outn_valid` and `outn_data` immediately after edge k.
- Throughput: 1 beat/cycle into one destination while its `outn_ready` is held at 1.
- Stall: with the destination full and its `outn_ready=0`, `in_ready=0`. Upstream must hold `in_valid`, `in_data`, `in_last` and `in_sel` until accepted.
- A packet locked to a stalled destination blocks the input. Beats of the next packet are not reordered around it.

## Test plan

- Reset: drive `rst_n=0` with random inputs. Required: `out0_valid=out1_valid=0`, all data and last outputs 0, `in_ready=1`. Releasing reset keeps all of these values.
- One-beat packet: send `in_sel=0`, `in_data=5'h15`, `in_last=1` with `out0_ready=1`. Required: after the next edge `out0_valid=1`, `out0_data=5'h15` and `out0_last=1`; one cycle later `out0_valid=0`; `out1_valid` stays 0 throughout.
- Packet lock: send a 3-beat packet with `in_sel=1` and data 5'h0A, 5'h15, 5'h1F, driving `in_sel=0` on beats 2 and 3. Required: all three beats appear on out1 in order on consecutive cycles, `out1_last=1` only on 5'h1F, and `out0_valid` stays 0.
- Backpressure: hold `out0_ready=0` and send beats 5'h01 then 5'h02, both with `in_sel=0` and `in_last=1`. Required:
  - 5'h01 is held on `out0_data` and `in_ready=0` while 5'h02 is presented.
  - After raising `out0_ready`, `in_ready=1` in the same cycle and 5'h02 is shown on `out0_data` the next cycle.
  - No duplicate of 5'h01 appears.
- Independent drain: out0 holds 5'h03 with `out0_ready=0`; send 5'h04 with `in_sel=1`, `in_last=1`, `out1_ready=1`. Required: the beat is accepted immediately, `out1_data=5'h04` next cycle, and `out0_data` stays 5'h03.
- Reset mid-packet: pulse `rst_n` low after beat 1 of a 3-beat packet to out1. Required: `out1_valid=0` during reset. Then send 5'h0A with `in_sel=0`, `in_last=1`. Required: it appears on out0, not out1.

Source files
------------

// File: rtl/stream_demux.sv
// stream_demux: registered 1-to-2 packet demultiplexer.
// Each packet is steered as a whole to out0 or out1, chosen by in_sel on the
// packet's first beat. Each output owns a one-entry register, so the two
// destinations drain independently and input data never reaches output data
// combinationally.
//
// Handshake: a beat moves across any valid/ready interface at a rising edge
// where valid and ready are both high. A producer holding valid high keeps its
// payload stable until that edge; ready never depends on the same
// interface's valid.
module stream_demux #(
   parameter int WIDTH = 5
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   input  logic             in_last,
   input  logic             in_sel,
   output logic             out0_valid,
   input  logic             out0_ready,
   output logic [WIDTH-1:0] out0_data,
   output logic             out0_last,
   output logic             out1_valid,
   input  logic             out1_ready,
   output logic [WIDTH-1:0] out1_data,
   output logic             out1_last
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      LOCK0 = 2'd1,
      LOCK1 = 2'd2
   } state_t;

   // Packet state is kept as a named enum so checkers can bind to it.
   state_t state;
   state_t state_next;

   logic dest;
   logic accept;
   logic load0;
   logic load1;

   // Destination: in_sel between packets, the locked output mid-packet.
   always_comb begin
      dest = 1'b0;
      case (state)
         IDLE:    dest = in_sel;
         LOCK0:   dest = 1'b0;
         LOCK1:   dest = 1'b1;
         default: dest = 1'b0;
      endcase
   end

   // Ready when the destination register is empty or draining this cycle.
   assign in_ready = dest ? (!out1_valid || out1_ready)
                          : (!out0_valid || out0_ready);
   assign accept   = in_valid && in_ready;
   assign load0    = accept && !dest;
   assign load1    = accept && dest;

   // Next packet state: a non-last beat locks, a last beat returns to IDLE.
   always_comb begin
      state_next = state;
      case (state)
         IDLE: begin
            if (accept && !in_last) begin
               state_next = in_sel ? LOCK1 : LOCK0;
            end
         end
         LOCK0, LOCK1: begin
            if (accept && in_last) begin
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   // Packet state register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Output 0 register: a load wins over a drain so valid stays high.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out0_valid <= 1'b0;
         out0_data  <= '0;
         out0_last  <= 1'b0;
      end else if (load0) begin
         out0_valid <= 1'b1;
         out0_data  <= in_data;
         out0_last  <= in_last;
      end else if (out0_valid && out0_ready) begin
         out0_valid <= 1'b0;
      end
   end

   // Output 1 register: a load wins over a drain so valid stays high.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out1_valid <= 1'b0;
         out1_data  <= '0;
         out1_last  <= 1'b0;
      end else if (load1) begin
         out1_valid <= 1'b1;
         out1_data  <= in_data;
         out1_last  <= in_last;
      end else if (out1_valid && out1_ready) begin
         out1_valid <= 1'b0;
      end
   end

endmodule
